// File: rtl/needs_engine.sv
// needs_engine: parametrised need-level bookkeeping with staggered decay,
// replenish actions, rest recovery and starvation tracking to DEAD.
module needs_engine #(
    parameter int N_CH       = 5,
    parameter int WIDTH      = 3,
    parameter int TICK_DIV   = 50000000,
    parameter int DECAY_BASE = 10,
    parameter int DECAY_STEP = 2,
    parameter int REFILL     = 3,
    parameter int LOW_THR    = 2,
    parameter int DEAD_SECS  = 30,
    parameter int REST_CH    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              velocidad,
    input  logic [N_CH-1:0]         accion,
    input  logic                    reposo,
    input  logic                    test,
    output logic [N_CH*WIDTH-1:0]   niveles,
    output logic [N_CH-1:0]         alarma,
    output logic [1:0]              estado,
    output logic                    sec_tick
);

    localparam int MAX  = (1 << WIDTH) - 1;
    localparam int PMAX = DECAY_BASE + (N_CH - 1) * DECAY_STEP;
    localparam int CW   = $clog2(PMAX + 1);
    localparam int PW   = $clog2(TICK_DIV + 1);
    localparam int SW   = $clog2(DEAD_SECS + 1);

    localparam logic [WIDTH:0]   MAXW = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   REFW = (WIDTH+1)'(REFILL);
    localparam logic [WIDTH-1:0] THR  = WIDTH'(LOW_THR);
    localparam logic [SW-1:0]    DSEC = SW'(DEAD_SECS);

    typedef enum logic [1:0] {
        OK    = 2'd0,
        NEEDY = 2'd1,
        CRIT  = 2'd2,
        DEAD  = 2'd3
    } st_t;

    st_t              state, state_nx;
    logic [PW-1:0]    cnt, tdiv, term;
    logic [SW-1:0]    starve, starve_nx;
    logic [WIDTH-1:0] lvl    [N_CH];
    logic [WIDTH-1:0] lvl_nx [N_CH];
    logic [CW-1:0]    cd     [N_CH];
    logic [CW-1:0]    cd_nx  [N_CH];
    logic [N_CH-1:0]  dtick, zero_nx, alarm_nx;
    logic             any_zero, dead;

    function automatic logic [CW-1:0] period(input int i);
        return CW'(DECAY_BASE + i * DECAY_STEP);
    endfunction

    function automatic logic [WIDTH-1:0] add_sat(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH:0]   b
    );
        logic [WIDTH:0] s;
        s = {1'b0, a} + b;
        return (s > MAXW) ? WIDTH'(MAX) : s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sub_sat(input logic [WIDTH-1:0] a);
        logic [WIDTH:0] s;
        s = {1'b0, a} - (WIDTH+1)'(1);
        return s[WIDTH] ? '0 : s[WIDTH-1:0];
    endfunction

    assign dead   = (state == DEAD);
    assign estado = state;

    for (genvar g = 0; g < N_CH; g++) begin : g_pack
        assign niveles[g*WIDTH +: WIDTH] = lvl[g];
    end

    // Prescaler terminal for the selected speed, never below one cycle.
    always_comb begin
        tdiv = PW'(TICK_DIV) >> velocidad;
        term = (tdiv > PW'(1)) ? tdiv - PW'(1) : '0;
    end

    // Seconds prescaler; >= compare keeps speed changes mid-count safe.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            sec_tick <= 1'b0;
        end else if (cnt >= term) begin
            cnt      <= '0;
            sec_tick <= 1'b1;
        end else begin
            cnt      <= cnt + PW'(1);
            sec_tick <= 1'b0;
        end
    end

    // Next-state levels, countdowns, starvation count and global state.
    always_comb begin
        any_zero = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            dtick[i]  = sec_tick && (cd[i] == CW'(1));
            cd_nx[i]  = cd[i];
            lvl_nx[i] = lvl[i];
            if (!dead && (test || accion[i])) begin
                cd_nx[i] = period(i);
            end else if (sec_tick) begin
                cd_nx[i] = dtick[i] ? period(i) : cd[i] - CW'(1);
            end
            if (!dead) begin
                if (test) begin
                    lvl_nx[i] = THR;
                end else if (accion[i]) begin
                    lvl_nx[i] = add_sat(lvl[i], REFW);
                end else if (dtick[i] && reposo && i == REST_CH) begin
                    lvl_nx[i] = add_sat(lvl[i], (WIDTH+1)'(1));
                end else if (dtick[i]) begin
                    lvl_nx[i] = sub_sat(lvl[i]);
                end
            end
            zero_nx[i]  = (lvl_nx[i] == '0);
            alarm_nx[i] = (lvl_nx[i] <= THR);
            if (lvl[i] == '0) any_zero = 1'b1;
        end

        if (!any_zero)
            starve_nx = '0;
        else if (sec_tick && starve < DSEC)
            starve_nx = starve + SW'(1);
        else
            starve_nx = starve;

        if (dead || starve_nx == DSEC)
            state_nx = DEAD;
        else if (|zero_nx)
            state_nx = CRIT;
        else if (|alarm_nx)
            state_nx = NEEDY;
        else
            state_nx = OK;
    end

    // Register levels, countdowns, alarms, starvation and state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                lvl[i] <= WIDTH'(MAX);
                cd[i]  <= period(i);
            end
            alarma <= '0;
            starve <= '0;
            state  <= OK;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                lvl[i] <= lvl_nx[i];
                cd[i]  <= cd_nx[i];
            end
            alarma <= alarm_nx;
            starve <= starve_nx;
            state  <= state_nx;
        end
    end

endmodule
